// File: rtl/morse_player.sv
// rtl/morse_player.sv - Morse element sequencer with unit timing, repeat word gap, abort and busy/done status
module morse_player #(
    parameter int MAX_LEN     = 4,
    parameter int LEN_W       = 3,
    parameter int UNIT_CYCLES = 25000000,
    parameter int DASH_UNITS  = 3,
    parameter int GAP_UNITS   = 1,
    parameter int WORD_UNITS  = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               repeat_en,
    input  logic [MAX_LEN-1:0] mcode,
    input  logic [LEN_W-1:0]   mlength,
    output logic               ss,
    output logic               ls,
    output logic               busy,
    output logic               done
);

    localparam int UC_W      = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int MAX_UNITS = (DASH_UNITS > WORD_UNITS) ? DASH_UNITS : WORD_UNITS;
    localparam int UN_W      = $clog2(MAX_UNITS);
    localparam int IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [UC_W-1:0]  UNIT_LAST  = UC_W'(UNIT_CYCLES - 1);
    localparam logic [UN_W-1:0]  DOT_LAST   = '0;
    localparam logic [UN_W-1:0]  DASH_LAST  = UN_W'(DASH_UNITS - 1);
    localparam logic [UN_W-1:0]  GAP_LAST   = UN_W'(GAP_UNITS - 1);
    localparam logic [UN_W-1:0]  WGAP_LAST  = UN_W'(WORD_UNITS - GAP_UNITS - 1);
    localparam logic [LEN_W-1:0] MAX_LEN_L  = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        WORDGAP
    } state_t;

    state_t             state_q, state_d;
    logic [UC_W-1:0]    unit_q, unit_d;
    logic [UN_W-1:0]    units_q, units_d;
    logic [MAX_LEN-1:0] code_q, code_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ss_q, ss_d;
    logic               ls_q, ls_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               unit_end;
    logic               is_last;
    logic [UN_W-1:0]    mark_last;
    logic [LEN_W-1:0]   len_clamped;
    logic               next_dash;

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        len_d       = len_q;
        idx_d       = idx_q;
        done_d      = 1'b0;

        unit_end    = (unit_q == UNIT_LAST);
        is_last     = ((LEN_W'(idx_q) + LEN_W'(1)) == len_q);
        mark_last   = code_q[idx_q] ? DASH_LAST : DOT_LAST;
        len_clamped = (mlength > MAX_LEN_L) ? MAX_LEN_L : mlength;

        if (unit_end) begin
            unit_d  = '0;
            units_d = units_q + UN_W'(1);
        end else begin
            unit_d  = unit_q + UC_W'(1);
            units_d = units_q;
        end

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    code_d = mcode;
                    len_d  = len_clamped;
                    idx_d  = '0;
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = MARK;
                    end
                end
            end
            MARK: begin
                if (unit_end && units_q == mark_last) begin
                    state_d = SPACE;
                end
            end
            SPACE: begin
                if (unit_end && units_q == GAP_LAST) begin
                    if (!is_last) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = MARK;
                    end else if (repeat_en) begin
                        state_d = WORDGAP;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            WORDGAP: begin
                if (unit_end && units_q == WGAP_LAST) begin
                    idx_d   = '0;
                    state_d = MARK;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever transition was chosen above.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        if (state_d != state_q || state_d == IDLE) begin
            unit_d  = '0;
            units_d = '0;
        end

        // Outputs are decoded from the next state so they line up with the state register.
        next_dash = code_d[idx_d];
        ss_d      = (state_d == MARK) && !next_dash;
        ls_d      = (state_d == MARK) && next_dash;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            unit_q  <= '0;
            units_q <= '0;
            code_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            ss_q    <= 1'b0;
            ls_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            units_q <= units_d;
            code_q  <= code_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            ss_q    <= ss_d;
            ls_q    <= ls_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ss   = ss_q;
    assign ls   = ls_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
